// File: rtl/ram_dram_clocked.sv
// ram_dram_clocked: cycle-based multiplexed-address DRAM model with page mode, early/late write,
// RAS-only and CBR refresh, and per-row refresh-age tracking.
module ram_dram_clocked #(
    parameter int                  DQ_WIDTH      = 4,
    parameter int                  ROW_BITS      = 8,
    parameter int                  COL_BITS      = 8,
    parameter logic [DQ_WIDTH-1:0] INIT_PATTERN  = 4'b1001,
    parameter int unsigned         REFRESH_LIMIT = 4096,
    parameter logic [DQ_WIDTH-1:0] DECAY_VALUE   = '0,
    localparam int                 AW            = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                _RAS,
    input  logic                _CAS,
    input  logic                _WE,
    input  logic                _OE,
    input  logic [AW-1:0]       A,
    inout  wire  [DQ_WIDTH-1:0] DQ,
    output logic                REFRESH_ERR,
    output logic [ROW_BITS-1:0] CBR_ROW
);
    typedef enum logic [1:0] {S_IDLE, S_ROW_OPEN, S_ACCESS, S_CBR} state_t;
    state_t r_state, w_next;
    logic r_ras_q, r_cas_q, r_we_q;
    logic [ROW_BITS-1:0] r_row, r_cbr;
    logic [COL_BITS-1:0] r_col;
    logic [DQ_WIDTH-1:0] r_dout;
    logic r_valid, r_decayed, r_err;
    logic [31:0] r_cycle;
    logic [31:0] r_stamp [2**ROW_BITS];
    // Contents survive RESET, so the power-up pattern lives in the declaration rather than a reset branch.
    logic [DQ_WIDTH-1:0] r_mem [2**(ROW_BITS+COL_BITS)] = '{default: INIT_PATTERN};
    logic w_ras_fall, w_ras_rise, w_cas_fall, w_cas_rise, w_we_fall;
    logic w_open, w_cbr, w_rd, w_wr_early, w_wr_late, w_wr, w_row_decayed, w_drive;
    logic [ROW_BITS-1:0] w_a_row;
    logic [COL_BITS-1:0] w_col;
    logic [ROW_BITS+COL_BITS-1:0] w_addr;
    assign w_ras_fall = r_ras_q & ~_RAS;
    assign w_ras_rise = ~r_ras_q & _RAS;
    assign w_cas_fall = r_cas_q & ~_CAS;
    assign w_cas_rise = ~r_cas_q & _CAS;
    assign w_we_fall  = r_we_q & ~_WE;
    assign w_a_row    = A[ROW_BITS-1:0];
    assign w_col      = (r_state == S_ROW_OPEN) ? A[COL_BITS-1:0] : r_col;
    assign w_addr     = {r_row, w_col};
    assign w_wr       = w_wr_early | w_wr_late;
    // Age is judged at the RAS fall, before that fall re-stamps the row.
    assign w_row_decayed = (REFRESH_LIMIT != 0) && ((r_cycle - r_stamp[w_a_row]) > 32'(REFRESH_LIMIT));
    assign w_drive    = (r_state == S_ACCESS) && !_CAS && !_OE && _WE && r_valid;
    assign DQ         = w_drive ? r_dout : 'z;
    assign REFRESH_ERR = r_err;
    assign CBR_ROW     = r_cbr;
    always_ff @(posedge CLK) r_state <= RESET ? S_IDLE : w_next;
    always_comb begin
        w_next     = r_state;
        w_open     = 1'b0;
        w_cbr      = 1'b0;
        w_rd       = 1'b0;
        w_wr_early = 1'b0;
        w_wr_late  = 1'b0;
        case (r_state)
            S_IDLE: if (w_ras_fall) begin
                w_cbr  = ~_CAS;
                w_open = _CAS;
                w_next = _CAS ? S_ROW_OPEN : S_CBR;
            end
            S_ROW_OPEN: if (w_ras_rise) w_next = S_IDLE;
                else if (w_cas_fall) begin
                    w_next     = S_ACCESS;
                    w_rd       = _WE;
                    w_wr_early = ~_WE;
                end
            S_ACCESS: if (w_ras_rise) w_next = S_IDLE;
                else if (w_cas_rise) w_next = S_ROW_OPEN;
                else if (w_we_fall && !_CAS) w_wr_late = 1'b1;
            S_CBR: if (w_ras_rise) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) if (!RESET && w_wr) r_mem[w_addr] <= DQ;
    always_ff @(posedge CLK) begin
        r_ras_q <= _RAS;
        r_cas_q <= _CAS;
        r_we_q  <= _WE;
        if (RESET) begin
            r_row     <= '0;
            r_col     <= '0;
            r_cbr     <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_decayed <= 1'b0;
            r_err     <= 1'b0;
            r_cycle   <= '0;
            for (int i = 0; i < 2**ROW_BITS; i++) r_stamp[i] <= '0;
        end else begin
            r_cycle <= (r_cycle == '1) ? r_cycle : r_cycle + 32'd1;
            if (w_open) begin
                r_row            <= w_a_row;
                r_decayed        <= w_row_decayed;
                r_stamp[w_a_row] <= r_cycle;
            end
            if (w_cbr) begin
                r_stamp[r_cbr] <= r_cycle;
                r_cbr          <= r_cbr + 1'b1;
            end
            if (w_rd | w_wr) begin
                r_stamp[r_row] <= r_cycle;
                r_err          <= r_err | r_decayed;
            end
            if (w_rd | w_wr_early) r_col <= A[COL_BITS-1:0];
            if (w_rd) r_dout <= r_decayed ? DECAY_VALUE : r_mem[w_addr];
            if (w_rd | w_wr_late) r_valid <= 1'b1;
            if (w_wr_early) r_valid <= 1'b0;
            if (w_wr_late) r_dout <= DQ;
            // Freshly written data is good, so later reads in this RAS cycle return it.
            if (w_wr) r_decayed <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_dram_clocked.sv
// tb_ram_dram_clocked: directed vectors for ram_dram_clocked; a released DQ bus reads back as all ones.
module tb_ram_dram_clocked;
    localparam logic [3:0] Z = 4'hF;
    logic clk = 1'b0, rst = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, oe_n = 1'b0;
    logic [7:0] a = '0;
    logic dq_en = 1'b0;
    logic [3:0] dq_drv = '0;
    tri1 [3:0] dq;
    logic refresh_err;
    logic [7:0] cbr_row;
    int n_chk = 0, n_err = 0;
    typedef struct {
        logic rst, ras_n, cas_n, we_n;
        logic [7:0] a;
        logic dq_en;
        logic [3:0] dq_drv;
        logic chk, chk_dq;
        logic [3:0] exp_dq;
        logic [7:0] exp_cbr;
        logic exp_err;
    } vec_t;
    vec_t tbl[$];
    assign dq = dq_en ? dq_drv : 'z;
    always #5 clk = ~clk;
    ram_dram_clocked #(.REFRESH_LIMIT(100)) dut (
        .CLK(clk), .RESET(rst), ._RAS(ras_n), ._CAS(cas_n), ._WE(we_n), ._OE(oe_n),
        .A(a), .DQ(dq), .REFRESH_ERR(refresh_err), .CBR_ROW(cbr_row)
    );
    function automatic vec_t v(input logic r, input logic ras, input logic cas, input logic we,
                               input logic [7:0] ad, input logic en, input logic [3:0] d,
                               input logic cd, input logic [3:0] ed, input logic [7:0] ec, input logic ee);
        vec_t x;
        x.rst = r; x.ras_n = ras; x.cas_n = cas; x.we_n = we; x.a = ad; x.dq_en = en; x.dq_drv = d;
        x.chk = 1'b1; x.chk_dq = cd; x.exp_dq = ed; x.exp_cbr = ec; x.exp_err = ee;
        return x;
    endfunction
    function automatic vec_t idle();
        vec_t x = v(0, 1, 1, 1, 8'h00, 0, 4'h0, 0, 4'h0, 8'h00, 0);
        x.chk = 1'b0;
        return x;
    endfunction
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic apply(input vec_t x, input string tag);
        rst = x.rst; ras_n = x.ras_n; cas_n = x.cas_n; we_n = x.we_n; a = x.a;
        dq_en = x.dq_en; dq_drv = x.dq_drv;
        @(posedge clk); #1;
        if (x.chk) begin
            if (x.chk_dq) chk({tag, "_dq"}, {4'h0, dq}, {4'h0, x.exp_dq});
            chk({tag, "_cbr"}, cbr_row, x.exp_cbr);
            chk({tag, "_err"}, {7'h0, refresh_err}, {7'h0, x.exp_err});
        end
    endtask
    initial begin
        // power-up read of (12,34)
        tbl.push_back(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h12, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h34, 0, 4'h0, 1, 4'h9, 8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h34, 0, 4'h0, 1, 4'h9, 8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h34, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        // early write A at (05,07), then read back
        tbl.push_back(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h05, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'h07, 1, 4'hA, 0, 4'h0, 8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h05, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h07, 0, 4'h0, 1, 4'hA, 8'h00, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        // page mode on row 20
        tbl.push_back(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h20, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 4'h3, 0, 4'h0, 8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'h01, 1, 4'h4, 0, 4'h0, 8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h01, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'h02, 1, 4'h5, 0, 4'h0, 8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h02, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 4'h0, 1, 4'h3, 8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h01, 0, 4'h0, 1, 4'h4, 8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h01, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h02, 0, 4'h0, 1, 4'h5, 8'h00, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        // read-modify-write at (01,01)
        tbl.push_back(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h01, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h01, 0, 4'h0, 1, 4'h9, 8'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'h01, 1, 4'h6, 0, 4'h0, 8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h01, 0, 4'h0, 1, 4'h6, 8'h00, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'h01, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h01, 0, 4'h0, 1, 4'h6, 8'h00, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        // CBR: lone CAS fall in IDLE ignored, two CAS-first cycles, one simultaneous fall
        tbl.push_back(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 4'h0, 1, Z,    8'h01, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h01, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'h00, 0, 4'h0, 1, Z,    8'h01, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 4'h0, 1, Z,    8'h02, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h02, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'h00, 0, 4'h0, 1, Z,    8'h03, 0));
        tbl.push_back(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h03, 0));
        tbl.push_back(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0));
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
        // read latency: bus stays released in the cycle CAS is first seen low
        apply(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z, 8'h00, 0), "lat_rst");
        apply(v(0, 0, 1, 1, 8'h12, 0, 4'h0, 1, Z, 8'h00, 0), "lat_ras");
        cas_n = 1'b0; a = 8'h34;
        #1 chk("lat_pre", {4'h0, dq}, {4'h0, Z});
        @(posedge clk); #1;
        chk("lat_post", {4'h0, dq}, 8'h09);
        apply(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z, 8'h00, 0), "lat_end");
        // decay: write row 7, idle 150 cycles, read back
        apply(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0), "dA_rst");
        apply(v(0, 0, 1, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0), "dA_ras");
        apply(v(0, 0, 0, 0, 8'h03, 1, 4'hC, 0, 4'h0, 8'h00, 0), "dA_wr");
        apply(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0), "dA_up");
        repeat (150) apply(idle(), "dA_idle");
        apply(v(0, 0, 1, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0), "dA_ras2");
        apply(v(0, 0, 0, 1, 8'h03, 0, 4'h0, 1, 4'h0, 8'h00, 1), "dA_rd");
        apply(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 1), "dA_sticky");
        // same, with a RAS-only refresh of row 7 near cycle 80
        apply(v(1, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0), "dB_rst");
        apply(v(0, 0, 1, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0), "dB_ras");
        apply(v(0, 0, 0, 0, 8'h03, 1, 4'h5, 0, 4'h0, 8'h00, 0), "dB_wr");
        apply(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0), "dB_up");
        repeat (75) apply(idle(), "dB_idle1");
        apply(v(0, 0, 1, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0), "dB_ref");
        apply(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0), "dB_ref_up");
        repeat (70) apply(idle(), "dB_idle2");
        apply(v(0, 0, 1, 1, 8'h07, 0, 4'h0, 1, Z,    8'h00, 0), "dB_ras2");
        apply(v(0, 0, 0, 1, 8'h03, 0, 4'h0, 1, 4'h5, 8'h00, 0), "dB_rd");
        apply(v(0, 1, 1, 1, 8'h00, 0, 4'h0, 1, Z,    8'h00, 0), "dB_end");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
